// File: rtl/rgb_stream_packer.sv
// Packs 24-bit {R,G,B} pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words) with SOF/EOL flags.
// Define PACKER_TESTPAT_EN to replace incoming pixels with a raster test pattern {x[7:0], y[7:0], 8'h80}.
//
// state | meaning
// PH0   | leftover empty; next pixel fills leftover, no word
// PH1   | leftover holds R,G,B; next pixel completes a word
// PH2   | leftover holds G,B; next pixel completes a word
// PH3   | leftover holds B; next pixel completes a word, leftover empties
module rgb_stream_packer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        in_valid,
  input  logic [23:0] in_pixel,
  output logic        in_ready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t        phase, phase_nxt;
  logic [23:0]   leftover, leftover_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic          sof_pend, sof_pend_nxt;
  logic          out_eof;

  logic          accept;
  logic          emit;
  logic [31:0]   word;
  logic          word_user, word_last, word_eof;
  logic [23:0]   pix;
  logic          x_end, y_end;

  assign in_ready = (phase == PH0) || !out_tvalid || out_tready;
  assign accept   = in_valid && in_ready;
  assign x_end    = (x == X_LAST);
  assign y_end    = (y == Y_LAST);

`ifdef PACKER_TESTPAT_EN
  assign pix = {8'(x), 8'(y), 8'h80};
`else
  assign pix = in_pixel;
`endif

  always_comb begin
    phase_nxt    = phase;
    leftover_nxt = leftover;
    x_nxt        = x;
    y_nxt        = y;
    sof_pend_nxt = sof_pend;
    emit         = 1'b0;
    word         = '0;
    word_user    = 1'b0;
    word_last    = 1'b0;
    word_eof     = 1'b0;
    if (accept) begin
      if (x_end) begin
        x_nxt = '0;
        y_nxt = y_end ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
      case (phase)
        PH0: begin
          leftover_nxt = pix;
          sof_pend_nxt = (x == '0) && (y == '0);
          phase_nxt    = PH1;
        end
        PH1: begin
          emit         = 1'b1;
          word         = {pix[23:16], leftover[7:0], leftover[15:8], leftover[23:16]};
          word_user    = sof_pend;
          leftover_nxt = {8'h00, pix[15:0]};
          phase_nxt    = PH2;
        end
        PH2: begin
          emit         = 1'b1;
          word         = {pix[15:8], pix[23:16], leftover[7:0], leftover[15:8]};
          leftover_nxt = {16'h0000, pix[7:0]};
          phase_nxt    = PH3;
        end
        PH3: begin
          emit         = 1'b1;
          word         = {pix[7:0], pix[15:8], pix[23:16], leftover[7:0]};
          word_last    = x_end;
          word_eof     = x_end && y_end;
          leftover_nxt = '0;
          phase_nxt    = PH0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase    <= PH0;
      leftover <= '0;
      x        <= '0;
      y        <= '0;
      sof_pend <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      leftover <= leftover_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      sof_pend <= sof_pend_nxt;
    end
  end

  // A new word may overwrite the held one only when it is being handshaken this same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tuser  <= 1'b0;
      out_tlast  <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_tvalid && out_tready && out_eof;
      if (emit) begin
        out_tvalid <= 1'b1;
        out_tdata  <= word;
        out_tuser  <= word_user;
        out_tlast  <= word_last;
        out_eof    <= word_eof;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Self-checking bench for rgb_stream_packer (H_RES=8, V_RES=2) using a byte-queue reference model.
module tb_rgb_stream_packer;
  localparam int H = 8;
  localparam int V = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        in_ready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tuser;
  logic        out_tlast;
  logic        frame_done;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.H_RES(H), .V_RES(V)) dut (
    .aclk(aclk), .aresetn(aresetn), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .frame_done(frame_done)
  );

  typedef struct packed {logic [7:0] b; logic sof; logic eol; logic eof;} byte_t;
  typedef struct packed {logic [31:0] data; logic user; logic last; logic eof;} word_t;

  byte_t bq[$];
  word_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int mx = 0;
  int my = 0;
  int words_seen = 0;
  int fd_count = 0;
  int user_seen = 0;
  logic [31:0] last_user_word = '0;
  logic fd_exp = 1'b0;
  bit rand_bp = 1'b0;

  // Byte-stream model: every accepted pixel appends R,G,B; every 4 bytes form a word.
  function automatic void model_accept(input logic [23:0] p);
    logic [23:0] px;
    byte_t e;
    word_t w;
`ifdef PACKER_TESTPAT_EN
    px = {mx[7:0], my[7:0], 8'h80};
`else
    px = p;
`endif
    e.b = px[23:16]; e.sof = (mx == 0 && my == 0); e.eol = 1'b0; e.eof = 1'b0;
    bq.push_back(e);
    e.b = px[15:8]; e.sof = 1'b0;
    bq.push_back(e);
    e.b = px[7:0]; e.eol = (mx == H-1); e.eof = (mx == H-1 && my == V-1);
    bq.push_back(e);
    mx++;
    if (mx == H) begin
      mx = 0;
      my++;
      if (my == V) my = 0;
    end
    while (bq.size() >= 4) begin
      w.data = {bq[3].b, bq[2].b, bq[1].b, bq[0].b};
      w.user = bq[0].sof;
      w.last = bq[3].eol;
      w.eof  = bq[3].eof;
      repeat (4) void'(bq.pop_front());
      sb.push_back(w);
    end
  endfunction

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge aclk) begin
    word_t w;
    if (!aresetn) begin
      fd_exp = 1'b0;
    end else begin
      n_checks++;
      if (frame_done !== fd_exp) begin
        n_fail++;
        $display("FAIL frame_done: got %b expected %b at %0t", frame_done, fd_exp, $time);
      end
      if (frame_done === 1'b1) fd_count++;
      fd_exp = 1'b0;
      if (out_tvalid && out_tready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word at %0t", out_tdata, $time);
        end else begin
          w = sb.pop_front();
          if ({out_tdata, out_tuser, out_tlast} !== {w.data, w.user, w.last}) begin
            n_fail++;
            $display("FAIL word: got data=%h user=%b last=%b expected data=%h user=%b last=%b at %0t",
                     out_tdata, out_tuser, out_tlast, w.data, w.user, w.last, $time);
          end
          words_seen++;
          if (out_tuser) begin
            user_seen++;
            last_user_word = out_tdata;
          end
          fd_exp = w.eof;
        end
      end
    end
  end

  task automatic send_pixel(input logic [23:0] p);
    int t = 0;
    in_valid = 1'b1;
    in_pixel = p;
    while (1) begin
      if (rand_bp) out_tready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (in_ready) begin
        model_accept(p);
        @(posedge aclk); #1;
        break;
      end
      @(posedge aclk); #1;
      t++;
      if (t > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", t);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({out_tvalid, out_tdata, out_tuser, out_tlast, frame_done} !== 36'h0) begin
      n_fail++;
      $display("FAIL %s_outputs: got valid=%b data=%h user=%b last=%b fd=%b expected all 0",
               tag, out_tvalid, out_tdata, out_tuser, out_tlast, frame_done);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b expected 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #2;
    check_reset_outputs("reset");
    wait_cycles(2);
    aresetn = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_packing();
    out_tready = 1'b1;
    send_pixel(24'h010203);
    send_pixel(24'h040506);
    send_pixel(24'h070809);
    send_pixel(24'h0A0B0C);
    wait_cycles(2);
    n_checks++;
    if (words_seen !== 3 || user_seen !== 1) begin
      n_fail++;
      $display("FAIL packing_count: got words=%0d users=%0d expected 3 and 1", words_seen, user_seen);
    end
`ifndef PACKER_TESTPAT_EN
    n_checks++;
    if (last_user_word !== 32'h04030201) begin
      n_fail++;
      $display("FAIL packing_first_word: got %h expected 04030201", last_user_word);
    end
`endif
  endtask

  task automatic test_testpat();
`ifdef PACKER_TESTPAT_EN
    n_checks++;
    if (last_user_word !== 32'h01800000) begin
      n_fail++;
      $display("FAIL testpat_first_word: got %h expected 01800000", last_user_word);
    end
`endif
  endtask

  task automatic test_line_end();
    send_pixel(24'h111213);
    send_pixel(24'h212223);
    send_pixel(24'h313233);
    send_pixel(24'h414243);
    wait_cycles(2);
    n_checks++;
    if (words_seen !== 6) begin
      n_fail++;
      $display("FAIL line_end_count: got %0d expected 6", words_seen);
    end
  endtask

  task automatic test_frame_end();
    for (int i = 0; i < 8; i++) send_pixel(24'h500000 + 24'(i * 24'h010101));
    wait_cycles(3);
    n_checks++;
    if (words_seen !== 12 || fd_count !== 1) begin
      n_fail++;
      $display("FAIL frame_end: got words=%0d frame_done=%0d expected 12 and 1", words_seen, fd_count);
    end
    for (int i = 0; i < 4; i++) send_pixel(24'hA0B0C0 + 24'(i));
    wait_cycles(2);
    n_checks++;
    if (user_seen !== 2) begin
      n_fail++;
      $display("FAIL next_frame_user: got %0d tuser words expected 2", user_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    send_pixel(24'hC1C2C3);
    send_pixel(24'hC4C5C6);
    send_pixel(24'hC7C8C9);
    send_pixel(24'hCACBCC);
    out_tready = 1'b0;
    send_pixel(24'hD1D2D3);
    held = out_tdata;
    in_valid = 1'b1;
    in_pixel = 24'hE1E2E3;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_in_ready: got %b expected 0 (cycle %0d)", in_ready, i);
      end
      n_checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== held) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b data=%h expected 1 and %h", out_tvalid, out_tdata, held);
      end
      @(posedge aclk); #1;
    end
    out_tready = 1'b1;
    send_pixel(24'hE1E2E3);
    send_pixel(24'hF1F2F3);
    send_pixel(24'h0F1F2F);
    wait_cycles(3);
    n_checks++;
    if (words_seen !== 21 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got words=%0d pending=%0d expected 21 and 0", words_seen, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    int users0;
    send_pixel(24'h123456);
    send_pixel(24'h789ABC);
    out_tready = 1'b0;
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    bq.delete();
    mx = 0;
    my = 0;
    wait_cycles(2);
    aresetn = 1'b1;
    out_tready = 1'b1;
    users0 = user_seen;
    send_pixel(24'h010101);
    send_pixel(24'h020202);
    send_pixel(24'h030303);
    send_pixel(24'h040404);
    wait_cycles(2);
    n_checks++;
    if (user_seen !== users0 + 1) begin
      n_fail++;
      $display("FAIL midreset_sof: got %0d new tuser words expected 1", user_seen - users0);
    end
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_count;
    rand_bp = 1'b1;
    for (int i = 0; i < 32; i++) send_pixel(24'($urandom));
    rand_bp = 1'b0;
    out_tready = 1'b1;
    wait_cycles(6);
    n_checks++;
    if (sb.size() != 0 || fd_count !== fd0 + 2) begin
      n_fail++;
      $display("FAIL b2b_drain: got pending=%0d frames=%0d expected 0 and %0d",
               sb.size(), fd_count - fd0, 2);
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_testpat();
    test_line_end();
    test_frame_end();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
